// File: rtl/instruction_fetch_unit.sv
// ---------------------------------------------------------------------------
// instruction_fetch_unit
//
// Front end of the core. Owns the program counter, drives it straight into a
// combinational instruction ROM, and captures each returned word together
// with its address into a small prefetch FIFO. The FIFO head is offered to
// the decoder over a valid/ready handshake. Redirects (branch/call targets)
// flush the FIFO and reload the PC; Halt stops fetching but lets the FIFO
// drain.
//
// Handshake: the head transfers on any rising edge where InstValid and
// InstReady are both high. InstValid never depends on InstReady. InstOut and
// InstPC are meaningful only while InstValid is high. A transfer coinciding
// with RedirectValid is discarded along with the rest of the FIFO.
//
// Ports:
//   clk                 core clock
//   async_rst_n         asynchronous active-low reset (synchronous release)
//   InstructionAddress  address to the ROM, always equal to the PC register
//   InstructionIn       ROM word for InstructionAddress, same cycle
//   RedirectValid       load RedirectTarget into the PC and flush the FIFO
//   RedirectTarget      new PC value
//   Halt                stop fetching; queued entries still drain
//   InstValid           FIFO head is valid
//   InstReady           decoder accepts the head
//   InstOut             head instruction word
//   InstPC              address of the head instruction
//   FetchCount          (only with FETCH_PERF_COUNT_EN) accepted-pop counter
//
// Optional feature macro: FETCH_PERF_COUNT_EN adds the FetchCount output, a
// 16-bit wrapping count of instructions accepted by the decoder. It survives
// redirects and clears only on reset.
// ---------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] RESET_PC   = 16'h0000
) (
  input  logic        clk,
  input  logic        async_rst_n,
  output logic [15:0] InstructionAddress,
  input  logic [15:0] InstructionIn,
  input  logic        RedirectValid,
  input  logic [15:0] RedirectTarget,
  input  logic        Halt,
  output logic        InstValid,
  input  logic        InstReady,
  output logic [15:0] InstOut,
  output logic [15:0] InstPC
`ifdef FETCH_PERF_COUNT_EN
  ,
  output logic [15:0] FetchCount
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetchState_t;

  // State is kept as a named enum so checkers can bind to fetchState.
  fetchState_t fetchState;
  fetchState_t nextState;
  logic        fetchEnable;

  logic [15:0]   pc;
  logic [15:0]   memPc   [FIFO_DEPTH];
  logic [15:0]   memData [FIFO_DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic [CW-1:0] count;
  logic          pop;
  logic          push;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) fetchState <= RUN;
    else              fetchState <= nextState;
  end

  // ---------------- FSM: next state ----------------
  // Halt alone decides the state; a redirect never changes it.
  always_comb begin
    nextState = fetchState;
    unique case (fetchState)
      RUN:     if (Halt)  nextState = HALTED;
      HALTED:  if (!Halt) nextState = RUN;
      default: nextState = RUN;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    fetchEnable = 1'b0;
    unique case (fetchState)
      RUN:     fetchEnable = 1'b1;
      HALTED:  fetchEnable = 1'b0;
      default: fetchEnable = 1'b0;
    endcase
  end

  // ---------------- Datapath ----------------
  assign InstValid          = (count != '0);
  assign InstOut            = memData[rdPtr];
  assign InstPC             = memPc[rdPtr];
  assign InstructionAddress = pc;

  // A full FIFO may still accept a push when the head leaves in the same
  // cycle. Halt blocks the push already in the cycle it is first raised.
  assign pop  = InstValid & InstReady;
  assign push = fetchEnable & ~Halt & ~RedirectValid &
                ((count < CW'(FIFO_DEPTH)) | pop);

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      pc    <= RESET_PC;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        memPc[i]   <= '0;
        memData[i] <= '0;
      end
    end else if (RedirectValid) begin
      // Flush: storage is left as is, only the pointers and count reset.
      pc    <= RedirectTarget;
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        memPc[wrPtr]   <= pc;
        memData[wrPtr] <= InstructionIn;
        wrPtr          <= wrPtr + 1'b1;
        pc             <= pc + 16'd1;
      end
      if (pop) rdPtr <= rdPtr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH_PERF_COUNT_EN
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n)               FetchCount <= '0;
    else if (pop && !RedirectValid) FetchCount <= FetchCount + 16'd1;
  end
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

  localparam int          FIFO_DEPTH = 4;
  localparam logic [15:0] RESET_PC   = 16'h0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        async_rst_n;
  logic [15:0] InstructionAddress;
  logic [15:0] InstructionIn;
  logic        RedirectValid;
  logic [15:0] RedirectTarget;
  logic        Halt;
  logic        InstValid;
  logic        InstReady;
  logic [15:0] InstOut;
  logic [15:0] InstPC;
`ifdef FETCH_PERF_COUNT_EN
  logic [15:0] FetchCount;
`endif

  always #5 clk = ~clk;

  // Behavioural ROM: a few pinned words, hashed content elsewhere.
  function automatic logic [15:0] rom(input logic [15:0] a);
    case (a)
      16'h0000: rom = 16'h0000;
      16'h0001: rom = 16'hb00e;
      16'h000F: rom = 16'hcd07;
      default:  rom = (a * 16'h9e37) ^ 16'h3c5a;
    endcase
  endfunction

  assign InstructionIn = rom(InstructionAddress);

  instruction_fetch_unit #(.FIFO_DEPTH(FIFO_DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk                (clk),
    .async_rst_n        (async_rst_n),
    .InstructionAddress (InstructionAddress),
    .InstructionIn      (InstructionIn),
    .RedirectValid      (RedirectValid),
    .RedirectTarget     (RedirectTarget),
    .Halt               (Halt),
    .InstValid          (InstValid),
    .InstReady          (InstReady),
    .InstOut            (InstOut),
    .InstPC             (InstPC)
`ifdef FETCH_PERF_COUNT_EN
    ,
    .FetchCount         (FetchCount)
`endif
  );

  // ---------------- scoreboard / reference model ----------------
  // exp_q holds {pc, word} for every instruction the decoder should see,
  // in delivery order.
  logic [31:0] exp_q[$];
  logic [15:0] mPc;
  bit          mHalted;
  logic [15:0] mFetch;
  int          checks   = 0;
  int          failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    mPc     = RESET_PC;
    mHalted = 1'b0;
    mFetch  = '0;
  endtask

  // Advance the model by one edge using the inputs currently applied.
  task automatic model_update();
    bit popM;
    bit pushM;
    popM = (exp_q.size() != 0) && InstReady;
    if (RedirectValid) begin
      exp_q.delete();
      mPc = RedirectTarget;
    end else begin
      pushM = !mHalted && !Halt && ((exp_q.size() < FIFO_DEPTH) || popM);
      if (popM) begin
        void'(exp_q.pop_front());
        mFetch++;
      end
      if (pushM) begin
        exp_q.push_back({mPc, rom(mPc)});
        mPc++;
      end
    end
    mHalted = Halt;
  endtask

  task automatic check_all();
    chk("valid", {31'd0, InstValid}, {31'd0, exp_q.size() != 0});
    if (exp_q.size() != 0) begin
      chk("inst_pc",  {16'd0, InstPC},  {16'd0, exp_q[0][31:16]});
      chk("inst_out", {16'd0, InstOut}, {16'd0, exp_q[0][15:0]});
    end
    chk("addr", {16'd0, InstructionAddress}, {16'd0, mPc});
`ifdef FETCH_PERF_COUNT_EN
    chk("fetch_count", {16'd0, FetchCount}, {16'd0, mFetch});
`endif
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Asynchronous pulse between edges; checks the outputs drop without a clock.
  task automatic pulse_reset();
    #2;
    async_rst_n = 1'b0;
    #1;
    chk("rst_valid", {31'd0, InstValid}, 32'd0);
    chk("rst_addr",  {16'd0, InstructionAddress}, {16'd0, RESET_PC});
`ifdef FETCH_PERF_COUNT_EN
    chk("rst_fetch_count", {16'd0, FetchCount}, 32'd0);
`endif
    @(negedge clk);
    async_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    async_rst_n    = 1'b0;
    RedirectValid  = 1'b0;
    RedirectTarget = '0;
    Halt           = 1'b0;
    InstReady      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", {31'd0, InstValid}, 32'd0);
    chk("reset_out",   {16'd0, InstOut}, 32'd0);
    chk("reset_pc",    {16'd0, InstPC}, 32'd0);
    chk("reset_addr",  {16'd0, InstructionAddress}, {16'd0, RESET_PC});
    @(negedge clk);
    async_rst_n = 1'b1;

    // Streaming from reset with the decoder always ready.
    InstReady = 1'b1;
    step();
    chk("t1_e1_valid", {31'd0, InstValid}, 32'd1);
    chk("t1_e1_pc",    {16'd0, InstPC}, 32'h0000);
    chk("t1_e1_out",   {16'd0, InstOut}, 32'h0000);
    step();
    chk("t1_e2_pc",    {16'd0, InstPC}, 32'h0001);
    chk("t1_e2_out",   {16'd0, InstOut}, 32'hb00e);
    chk("t1_e2_addr",  {16'd0, InstructionAddress}, 32'h0002);
    steps(3);

    // Backpressure: fill, hold the address, then drain without gaps.
    pulse_reset();
    InstReady = 1'b0;
    steps(4);
    chk("t2_full_addr", {16'd0, InstructionAddress}, 32'h0004);
    step();
    chk("t2_hold_addr", {16'd0, InstructionAddress}, 32'h0004);
    chk("t2_head", {16'd0, InstPC}, 32'h0000);
    InstReady = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      step();
      chk($sformatf("t2_seq%0d", i), {16'd0, InstPC}, i);
    end

    // Redirect while PCs 3..6 are queued.
    pulse_reset();
    InstReady = 1'b0;
    steps(4);
    InstReady = 1'b1;
    steps(3);
    chk("t3_head3", {16'd0, InstPC}, 32'h0003);
    RedirectValid  = 1'b1;
    RedirectTarget = 16'h000E;
    step();
    chk("t3_r1_valid", {31'd0, InstValid}, 32'd0);
    RedirectValid = 1'b0;
    step();
    chk("t3_r2_pc",  {16'd0, InstPC}, 32'h000E);
    chk("t3_r2_out", {16'd0, InstOut}, {16'd0, rom(16'h000E)});
    step();
    chk("t3_r3_pc",  {16'd0, InstPC}, 32'h000F);
    chk("t3_r3_out", {16'd0, InstOut}, 32'hcd07);

    // Redirect to the top of the address space: PC wraps.
    RedirectValid  = 1'b1;
    RedirectTarget = 16'hFFFF;
    step();
    RedirectValid = 1'b0;
    step();
    chk("t4_pc_ffff", {16'd0, InstPC}, 32'h0000FFFF);
    step();
    chk("t4_pc_0000", {16'd0, InstPC}, 32'h00000000);
    step();
    chk("t4_pc_0001", {16'd0, InstPC}, 32'h00000001);

    // Halt with two entries queued: drain, freeze, then resume.
    pulse_reset();
    InstReady = 1'b0;
    steps(2);
    Halt      = 1'b1;
    InstReady = 1'b1;
    steps(3);
    chk("t5_empty", {31'd0, InstValid}, 32'd0);
    chk("t5_addr_hold", {16'd0, InstructionAddress}, 32'h0002);
    Halt = 1'b0;
    steps(2);
    chk("t5_resume_pc", {16'd0, InstPC}, 32'h0002);

    // Reset in the middle of a cycle with a full FIFO.
    InstReady = 1'b0;
    steps(5);
    pulse_reset();
    InstReady = 1'b1;
    step();
    chk("t6_first_pc", {16'd0, InstPC}, {16'd0, RESET_PC});

    // Randomised traffic against the model.
    for (int n = 0; n < 600; n++) begin
      InstReady      = ($urandom_range(0, 3) != 0);
      Halt           = ($urandom_range(0, 9) == 0) ? ~Halt : Halt;
      RedirectValid  = ($urandom_range(0, 19) == 0);
      RedirectTarget = ($urandom_range(0, 3) == 0) ? 16'(16'hFFFC + $urandom_range(0, 3))
                                                   : 16'($urandom_range(0, 65535));
      step();
    end
    RedirectValid = 1'b0;
    Halt          = 1'b0;
    steps(4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
